// File: rtl/ex_wb_flag_queue.sv
// In-order EX->WB result queue that commits masked flag updates into EFLAGS on pop.
// Optional FLAG_BYPASS_EN: spec_flags tracks the youngest queued op instead of eflags.
module ex_wb_flag_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     flush,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [DATA_W-1:0]        alu_out,
   input  logic [DATA_W-1:0]        alu_out_2,
   input  logic                     swap_cxc,
   input  logic [6:0]               flags_in,
   input  logic [6:0]               flag_mask,
   input  logic                     cc_inval,
   output logic                     pop_valid,
   input  logic                     pop_ready,
   output logic [DATA_W-1:0]        wb_out,
   output logic [DATA_W-1:0]        wb_out_2,
   output logic                     wb_swap,
   output logic [6:0]               eflags,
   output logic [6:0]               spec_flags,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] data_2;
      logic              swap;
      logic [6:0]        flags;
      logic [6:0]        mask;
      logic              cc_inval;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [6:0]         eflags_next;
   logic               push_fire;
   logic               pop_fire;

   assign push_ready = (count != FULL_CNT);
   assign pop_valid  = (count != '0);
   assign push_fire  = push_valid && push_ready && !flush;
   assign pop_fire   = pop_valid && pop_ready;

   assign head     = mem[rd_ptr];
   assign wb_out   = head.data;
   assign wb_out_2 = head.data_2;
   assign wb_swap  = head.swap;

   always_comb begin
      // NOTE: default first so every path assigns eflags_next and no latch is inferred.
      eflags_next = eflags;
      if (pop_fire && !head.cc_inval)
         eflags_next = (eflags & ~head.mask) | (head.flags & head.mask);
   end

   // NOTE: entry storage has no reset; pop_valid guards every read, so clearing it buys nothing.
   always_ff @(posedge clk) begin
      if (push_fire)
         mem[wr_ptr] <= '{alu_out, alu_out_2, swap_cxc, flags_in, flag_mask, cc_inval};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         eflags <= '0;
      end else begin
         eflags <= eflags_next;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push_fire) - CNT_W'(pop_fire);
         end
      end
   end

`ifdef FLAG_BYPASS_EN
   logic [6:0] spec_q;

   // Flush resynchronises to committed flags, including a same-edge commit.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         spec_q <= '0;
      else if (flush)
         spec_q <= eflags_next;
      else if (push_fire && !cc_inval)
         spec_q <= (spec_q & ~flag_mask) | (flags_in & flag_mask);
   end

   assign spec_flags = spec_q;
`else
   assign spec_flags = eflags;
`endif

endmodule

// File: tb/tb_ex_wb_flag_queue.sv
// Self-checking bench for ex_wb_flag_queue: directed steps plus a randomized phase,
// compared against a queue-based reference model of the flag-commit rules.
module tb_ex_wb_flag_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              clr;
   logic              flush;
   logic              push_valid;
   logic              push_ready;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] alu_out_2;
   logic              swap_cxc;
   logic [6:0]        flags_in;
   logic [6:0]        flag_mask;
   logic              cc_inval;
   logic              pop_valid;
   logic              pop_ready;
   logic [DATA_W-1:0] wb_out;
   logic [DATA_W-1:0] wb_out_2;
   logic              wb_swap;
   logic [6:0]        eflags;
   logic [6:0]        spec_flags;
   logic [2:0]        count;

   ex_wb_flag_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .clr(clr), .flush(flush),
      .push_valid(push_valid), .push_ready(push_ready),
      .alu_out(alu_out), .alu_out_2(alu_out_2), .swap_cxc(swap_cxc),
      .flags_in(flags_in), .flag_mask(flag_mask), .cc_inval(cc_inval),
      .pop_valid(pop_valid), .pop_ready(pop_ready),
      .wb_out(wb_out), .wb_out_2(wb_out_2), .wb_swap(wb_swap),
      .eflags(eflags), .spec_flags(spec_flags), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic [63:0] d2;
      logic        sw;
      logic [6:0]  f;
      logic [6:0]  m;
      logic        inv;
   } ent_t;

   ent_t       model_q[$];
   logic [6:0] m_eflags;
   int         checks = 0;
   int         errors = 0;

   function automatic logic [6:0] apply(logic [6:0] base, ent_t e);
      return e.inv ? base : ((base & ~e.m) | (e.f & e.m));
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected speculative flags: committed flags with every queued op applied in order.
   function automatic logic [6:0] exp_spec();
      logic [6:0] s;
      s = m_eflags;
`ifdef FLAG_BYPASS_EN
      foreach (model_q[i]) s = apply(s, model_q[i]);
`endif
      return s;
   endfunction

   task automatic check_all(string tag);
      check({tag, ".count"}, 64'(count), 64'(model_q.size()));
      check({tag, ".pop_valid"}, 64'(pop_valid), 64'(model_q.size() != 0));
      check({tag, ".push_ready"}, 64'(push_ready), 64'(model_q.size() < DEPTH));
      check({tag, ".eflags"}, 64'(eflags), 64'(m_eflags));
      check({tag, ".spec_flags"}, 64'(spec_flags), 64'(exp_spec()));
      if (model_q.size() != 0) begin
         check({tag, ".wb_out"}, wb_out, model_q[0].d);
         check({tag, ".wb_out_2"}, wb_out_2, model_q[0].d2);
         check({tag, ".wb_swap"}, 64'(wb_swap), 64'(model_q[0].sw));
      end
   endtask

   // Drive one cycle's inputs, advance past the edge, update the model, compare.
   task automatic step(string tag, logic pv, logic [63:0] d, logic [63:0] d2, logic sw,
                       logic [6:0] f, logic [6:0] m, logic inv, logic pr, logic fl);
      ent_t e;
      bit   push_ok, pop_ok;
      push_valid = pv; alu_out = d; alu_out_2 = d2; swap_cxc = sw;
      flags_in = f; flag_mask = m; cc_inval = inv; pop_ready = pr; flush = fl;
      push_ok = pv && (model_q.size() < DEPTH) && !fl;
      pop_ok  = pr && (model_q.size() != 0);
      e = '{d, d2, sw, f, m, inv};
      @(posedge clk);
      #1;
      if (pop_ok) m_eflags = apply(m_eflags, model_q.pop_front());
      if (fl) model_q.delete();
      else if (push_ok) model_q.push_back(e);
      check_all(tag);
   endtask

   initial begin
      clr = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
      alu_out = '0; alu_out_2 = '0; swap_cxc = 1'b0;
      flags_in = '0; flag_mask = '0; cc_inval = 1'b0;
      m_eflags = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      clr = 1'b1;
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("idle.eflags_zero", 64'(eflags), 64'h00);

      // Single op
      step("single.push", 1, 64'h1234, 64'h55, 1, 7'h41, 7'h7F, 0, 1, 0);
      check("single.visible", wb_out, 64'h1234);
      step("single.pop", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("single.eflags", 64'(eflags), 64'h41);

      // Fill and refuse
      for (int i = 0; i < 4; i++)
         step("fill", 1, 64'(i), 64'(i + 100), i[0], 7'h7F, 7'h7F, 0, 0, 0);
      check("fill.push_ready", 64'(push_ready), 64'h0);
      step("fill.refuse", 1, 64'h99, 0, 0, 0, 7'h7F, 0, 1, 0);
      check("fill.count3", 64'(count), 64'h3);
      for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("drain.eflags", 64'(eflags), 64'h7F);

      // Masked and invalid commit
      step("mask.pushA", 1, 64'hA, 0, 0, 7'h00, 7'h01, 0, 0, 0);
      step("mask.pushB", 1, 64'hB, 0, 0, 7'h00, 7'h7F, 1, 0, 0);
      step("mask.popA", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("mask.eflags_7e", 64'(eflags), 64'h7E);
      step("mask.popB", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("inval.eflags_7e", 64'(eflags), 64'h7E);

      // Wrap-around at one push/pop per cycle
      step("wrap.prime", 1, 64'h1000, 0, 0, 7'h00, 7'h00, 0, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         step("wrap", 1, 64'h1000 + 64'(i), 0, 0, 7'h00, 7'h00, 0, 1, 0);
         check("wrap.count1", 64'(count), 64'h1);
      end
      step("wrap.last", 0, 0, 0, 0, 0, 0, 0, 1, 0);

      // Flush mid-stream
      step("flush.clear", 1, 64'h1, 0, 0, 7'h00, 7'h7F, 0, 0, 0);
      step("flush.clearpop", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("flush.q0", 1, 64'h20, 0, 0, 7'h04, 7'h04, 0, 0, 0);
      step("flush.q1", 1, 64'h21, 0, 0, 7'h7F, 7'h7F, 0, 0, 0);
      step("flush.q2", 1, 64'h22, 0, 0, 7'h10, 7'h30, 0, 0, 0);
      step("flush.edge", 1, 64'h23, 0, 0, 7'h7F, 7'h7F, 0, 1, 1);
      check("flush.count0", 64'(count), 64'h0);
      check("flush.eflags_bit2", 64'(eflags[2]), 64'h1);
`ifdef FLAG_BYPASS_EN
      check("flush.spec_eq", 64'(spec_flags), 64'h04);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", $urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 7'($urandom), 7'($urandom), $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_wb_flag_queue.md
Name: ex_wb_flag_queue

Overview:
Sits directly downstream of the EX-stage ALU top. It buffers ALU results, the CMPXCHG swap indication and per-op condition-code outputs in a small in-order FIFO, then hands them to writeback under a valid/ready handshake. On each pop it commits the masked flag update into the architectural EFLAGS subset register. That register's af/cf/of/zf bits are fed back to the ALU flag inputs.

Parameters:
DEPTH, 4, number of queue entries (power of two, at least 2)
DATA_W, 64, width of each result bus

Ports:
clk  in  1  stage clock; all state updates on the rising edge
clr  in  1  asynchronous, active-low reset
flush  in  1  discard all queued entries (pipeline squash)
push_valid  in  1  EX presents a completed op
push_ready  out  1  queue can accept; equals not full
alu_out  in  DATA_W  primary ALU result
alu_out_2  in  DATA_W  secondary result (pass-through of OP2)
swap_cxc  in  1  CMPXCHG swap indication
flags_in  in  7  {df,of,sf,zf,af,pf,cf}, bit 6 down to bit 0
flag_mask  in  7  1 = this op writes the corresponding flag
cc_inval  in  1  1 = op performs no flag update (zero-count shift)
pop_valid  out  1  head entry available to WB
pop_ready  in  1  WB accepts the head entry
wb_out  out  DATA_W  head alu_out
wb_out_2  out  DATA_W  head alu_out_2
wb_swap  out  1  head swap_cxc
eflags  out  7  committed flags, same bit order as flags_in
spec_flags  out  7  flags seen by the next op entering EX
count  out  clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (clr=0, asynchronous): read pointer = 0, write pointer = 0, count = 0, pop_valid = 0, eflags = 7'b0, spec_flags = 7'b0. Entry storage is not reset. The wb_* outputs are don't-care while pop_valid = 0.
- Push is accepted when push_valid & push_ready. The entry is written at the write pointer and the write pointer increments modulo DEPTH.
- Pop is accepted when pop_valid & pop_ready. The read pointer increments modulo DEPTH.
- wb_out, wb_out_2 and wb_swap are driven combinationally from the head entry (registered storage). Push-to-pop latency is 1 cycle: an entry pushed on edge N is visible with pop_valid = 1 after edge N.
- There is no fall-through when empty. push_ready is the registered-count "not full" and does not depend on pop_ready. When full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0.
- Commit on accepted pop:
  - If the head cc_inval = 0: eflags <= (eflags & ~mask) | (flags & mask), using the head entry's mask and flags.
  - If the head cc_inval = 1: eflags is unchanged.
- flush = 1 (sampled at the edge):
  - Pointers and count go to 0 and pop_valid goes to 0.
  - A push in the same cycle is dropped; flush has priority.
  - A pop accepted in the same cycle still commits its flags, so WB has already consumed it.
- The commit mask and flags travel with each entry: per entry, DATA_W*2 + 1 + 7 + 7 + 1 bits.

Optional Feature:
FLAG_BYPASS_EN
- Defined: spec_flags is a register.
  - On an accepted push with cc_inval = 0: spec <= (spec & ~flag_mask) | (flags_in & flag_mask).
  - On flush: spec <= the eflags value being written that edge, which includes any same-cycle commit.
  - Otherwise spec holds.
  - Result: the next op in EX sees the flags of the youngest queued op.
- Not defined: spec_flags = eflags (combinational copy). The issue logic must then stall flag readers while count != 0.

Test Plan:
- Reset then idle: clr low for 2 cycles, then high; push_valid = 0 -> pop_valid = 0, count = 0, push_ready = 1, eflags = 7'h00.
- Single op: push alu_out = 64'h1234, flags_in = 7'h41, mask = 7'h7F; pop_ready = 1 -> pop_valid rises the next cycle with wb_out = 64'h1234; after the pop edge eflags = 7'h41.
- Fill and refuse: 4 pushes with pop_ready = 0 -> count = 4, push_ready = 0. A 5th push together with a pop is refused; count = 3 afterwards and data order is preserved 0..3.
- Masked and invalid commit: with eflags = 7'h7F, pop an entry with mask = 7'h01 and flags = 7'h00 -> eflags = 7'h7E. Then pop an entry with cc_inval = 1 and flags = 7'h00, mask = 7'h7F -> eflags stays 7'h7E.
- Wrap-around: 10 push/pop pairs at one per cycle -> pointers wrap, count stays 1, wb_out sequence matches the push sequence exactly.
- Flush mid-stream: 3 entries queued; flush together with a push and a pop of the head (flags = 7'h04, mask = 7'h04) -> count = 0 and eflags bit 2 = 1. With FLAG_BYPASS_EN, spec_flags equals eflags after the edge.
